// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard and sequencing control logic.
package pipeline_ctrl_pkg;

  typedef enum logic {
    STATE_RUN  = 1'b0,
    STATE_BUSY = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO              = 5'd0;
  localparam int         DEFAULT_MULTI_LATENCY = 4;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard compare between the ID/EX load and the IF/ID sources.
module load_use_detector
  import pipeline_ctrl_pkg::*;
(
  input  logic       mem_read_i,
  input  logic [4:0] id_ex_rt_i,
  input  logic [4:0] if_id_rs_i,
  input  logic [4:0] if_id_rt_i,
  input  logic       if_id_valid_i,
  output logic       load_use_o
);

  // Register 0 never carries a real dependency, so it is exempt.
  assign load_use_o = mem_read_i & if_id_valid_i & (id_ex_rt_i != REG_ZERO) &
                      ((id_ex_rt_i == if_id_rs_i) | (id_ex_rt_i == if_id_rt_i));

endmodule

// File: rtl/ex_stall_controller.sv
// Execute-stage hazard controller: load-use bubble, multi-cycle ALU hold, branch flush
// and a saturating stall-cycle counter. State advances on the falling clock edge.
module ex_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULTI_LATENCY   = DEFAULT_MULTI_LATENCY,
  parameter int COUNT_WIDTH     = 3,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       idExMemRead,
  input  logic [4:0]                 idExRt,
  input  logic [4:0]                 ifIdRs,
  input  logic [4:0]                 ifIdRt,
  input  logic                       ifIdValid,
  input  logic                       multiStart,
  input  logic                       branchTaken,
  output logic                       pcWrite,
  output logic                       ifIdWrite,
  output logic                       ifIdFlush,
  output logic                       idExBubble,
  output logic                       exHold,
  output logic                       exMemBubble,
  output logic                       busy,
  output logic [STALL_CNT_WIDTH-1:0] stallCycles
);

  localparam bit                         MULTI_EN  = (MULTI_LATENCY > 1);
  localparam logic [COUNT_WIDTH-1:0]     CNT_ZERO  = COUNT_WIDTH'(0);
  localparam logic [COUNT_WIDTH-1:0]     CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]     CNT_LOAD  = COUNT_WIDTH'(MULTI_LATENCY - 1);
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = {STALL_CNT_WIDTH{1'b1}};
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = STALL_CNT_WIDTH'(1);

  state_e                     state_q, state_d;
  logic [COUNT_WIDTH-1:0]     count_q, count_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic                       load_use_s;

  load_use_detector u_load_use (
    .mem_read_i    (idExMemRead),
    .id_ex_rt_i    (idExRt),
    .if_id_rs_i    (ifIdRs),
    .if_id_rt_i    (ifIdRt),
    .if_id_valid_i (ifIdValid),
    .load_use_o    (load_use_s)
  );

  // Next-state and Mealy control outputs; held at RUN defaults while in reset.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    exHold      = 1'b0;
    exMemBubble = 1'b0;
    busy        = 1'b0;
    if (!resetN) begin
      state_d = STATE_RUN;
      count_d = CNT_ZERO;
    end else begin
      case (state_q)
        STATE_RUN: begin
          if (MULTI_EN && multiStart) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            exHold      = 1'b1;
            exMemBubble = 1'b1;
            state_d     = STATE_BUSY;
            count_d     = CNT_LOAD;
          end else if (branchTaken) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
          end else if (load_use_s) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
          end else begin
            state_d = STATE_RUN;
          end
        end
        STATE_BUSY: begin
          busy      = 1'b1;
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          if (count_q > CNT_ONE) begin
            exHold      = 1'b1;
            exMemBubble = 1'b1;
            count_d     = count_q - CNT_ONE;
          end else begin
            // Final cycle: result lands in EX/MEM; bubble ID/EX so the op cannot relaunch.
            idExBubble = 1'b1;
            state_d    = STATE_RUN;
            count_d    = CNT_ZERO;
          end
        end
        default: begin
          state_d = STATE_RUN;
          count_d = CNT_ZERO;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is frozen.
  always_comb begin
    stall_d = stall_q;
    if (!pcWrite && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State, countdown and stall counter registers on the pipeline's falling edge.
  always_ff @(negedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= STATE_RUN;
      count_q <= CNT_ZERO;
      stall_q <= {STALL_CNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  assign stallCycles = stall_q;

endmodule

// File: tb/tb_ex_stall_controller.sv
// Directed self-checking bench for ex_stall_controller; a second instance with a
// 3-bit stall counter covers saturation.
module tb_ex_stall_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       idExMemRead, ifIdValid, multiStart, branchTaken;
  logic [4:0] idExRt, ifIdRs, ifIdRt;

  logic        pcWrite, ifIdWrite, ifIdFlush, idExBubble, exHold, exMemBubble, busy;
  logic [15:0] stallCycles;
  logic        s_pcWrite, s_ifIdWrite, s_ifIdFlush, s_idExBubble, s_exHold, s_exMemBubble, s_busy;
  logic [2:0]  s_stallCycles;

  logic [6:0] out_s, sat_out_s;
  assign out_s     = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, exHold, exMemBubble, busy};
  assign sat_out_s = {s_pcWrite, s_ifIdWrite, s_ifIdFlush, s_idExBubble, s_exHold, s_exMemBubble, s_busy};

  // Output vector order: pcWrite ifIdWrite ifIdFlush idExBubble exHold exMemBubble busy
  localparam logic [6:0] O_DEF   = 7'b1100000;
  localparam logic [6:0] O_LU    = 7'b0001000;
  localparam logic [6:0] O_BR    = 7'b1111000;
  localparam logic [6:0] O_MRUN  = 7'b0000110;
  localparam logic [6:0] O_MBUSY = 7'b0000111;
  localparam logic [6:0] O_MLAST = 7'b0001001;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stall_controller u_dut (
    .clk(clk), .resetN(resetN), .idExMemRead(idExMemRead), .idExRt(idExRt),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdValid(ifIdValid), .multiStart(multiStart),
    .branchTaken(branchTaken), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
    .ifIdFlush(ifIdFlush), .idExBubble(idExBubble), .exHold(exHold),
    .exMemBubble(exMemBubble), .busy(busy), .stallCycles(stallCycles)
  );

  ex_stall_controller #(.STALL_CNT_WIDTH(3)) u_sat (
    .clk(clk), .resetN(resetN), .idExMemRead(idExMemRead), .idExRt(idExRt),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdValid(ifIdValid), .multiStart(multiStart),
    .branchTaken(branchTaken), .pcWrite(s_pcWrite), .ifIdWrite(s_ifIdWrite),
    .ifIdFlush(s_ifIdFlush), .idExBubble(s_idExBubble), .exHold(s_exHold),
    .exMemBubble(s_exMemBubble), .busy(s_busy), .stallCycles(s_stallCycles)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    idExMemRead = 1'b0; ifIdValid = 1'b0; multiStart = 1'b0; branchTaken = 1'b0;
    idExRt = 5'd0; ifIdRs = 5'd0; ifIdRt = 5'd0;
  endtask

  task automatic do_reset();
    tick();
    clear_inputs();
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetN = 1'b0;
    #2;
    n_checks++;
    if (out_s !== O_DEF) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=%b", out_s, O_DEF);
    end
    n_checks++;
    if (stallCycles !== 16'd0) begin
      n_fail++; $display("FAIL reset_stall got=%0d exp=0", stallCycles);
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    logic [4:0] rt_t [5] = '{5'd5, 5'd7, 5'd5, 5'd5, 5'd5};
    logic [4:0] rs_t [5] = '{5'd5, 5'd3, 5'd5, 5'd5, 5'd6};
    logic [4:0] r2_t [5] = '{5'd9, 5'd7, 5'd5, 5'd5, 5'd7};
    logic       mr_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vl_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       hz_t [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      idExMemRead = mr_t[i]; idExRt = rt_t[i]; ifIdRs = rs_t[i]; ifIdRt = r2_t[i];
      ifIdValid = vl_t[i];
      #1;
      n_checks++;
      if (out_s !== (hz_t[i] ? O_LU : O_DEF)) begin
        n_fail++; $display("FAIL load_use_case%0d got=%b exp=%b", i, out_s, hz_t[i] ? O_LU : O_DEF);
      end
      tick();
      idExMemRead = 1'b0;
      #1;
      n_checks++;
      if (out_s !== O_DEF || stallCycles !== (hz_t[i] ? 16'd1 : 16'd0)) begin
        n_fail++; $display("FAIL load_use_after%0d got=%b/%0d exp=%b/%0d", i, out_s, stallCycles,
                           O_DEF, hz_t[i] ? 1 : 0);
      end
      tick();
      n_checks++;
      if (stallCycles !== (hz_t[i] ? 16'd1 : 16'd0)) begin
        n_fail++; $display("FAIL load_use_hold%0d got=%0d exp=%0d", i, stallCycles, hz_t[i] ? 1 : 0);
      end
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    idExMemRead = 1'b1; idExRt = 5'd0; ifIdRs = 5'd0; ifIdRt = 5'd0; ifIdValid = 1'b1;
    #1;
    n_checks++;
    if (out_s !== O_DEF) begin
      n_fail++; $display("FAIL reg_zero_outputs got=%b exp=%b", out_s, O_DEF);
    end
    tick();
    n_checks++;
    if (stallCycles !== 16'd0) begin
      n_fail++; $display("FAIL reg_zero_stall got=%0d exp=0", stallCycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    idExMemRead = 1'b1; idExRt = 5'd5; ifIdRs = 5'd5; ifIdValid = 1'b1; branchTaken = 1'b1;
    #1;
    n_checks++;
    if (out_s !== O_BR) begin
      n_fail++; $display("FAIL branch_over_load_use got=%b exp=%b", out_s, O_BR);
    end
    tick();
    idExMemRead = 1'b0;
    #1;
    n_checks++;
    if (out_s !== O_BR || stallCycles !== 16'd0) begin
      n_fail++; $display("FAIL branch_only got=%b/%0d exp=%b/0", out_s, stallCycles, O_BR);
    end
    tick();
    n_checks++;
    if (stallCycles !== 16'd0) begin
      n_fail++; $display("FAIL branch_stall got=%0d exp=0", stallCycles);
    end
  endtask

  task automatic test_multi();
    logic [6:0] exp_t [4] = '{O_MRUN, O_MBUSY, O_MBUSY, O_MLAST};
    do_reset();
    multiStart = 1'b1; branchTaken = 1'b1;
    idExMemRead = 1'b1; idExRt = 5'd5; ifIdRs = 5'd5; ifIdValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (out_s !== exp_t[i] || stallCycles !== 16'(i)) begin
        n_fail++; $display("FAIL multi_cycle%0d got=%b/%0d exp=%b/%0d", i, out_s, stallCycles,
                           exp_t[i], i);
      end
      tick();
    end
    clear_inputs();
    #1;
    n_checks++;
    if (out_s !== O_DEF || stallCycles !== 16'd4) begin
      n_fail++; $display("FAIL multi_done got=%b/%0d exp=%b/4", out_s, stallCycles, O_DEF);
    end
    tick();
    n_checks++;
    if (out_s !== O_DEF || stallCycles !== 16'd4) begin
      n_fail++; $display("FAIL multi_settled got=%b/%0d exp=%b/4", out_s, stallCycles, O_DEF);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    multiStart = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if (out_s !== O_MBUSY) begin
      n_fail++; $display("FAIL mid_busy_state got=%b exp=%b", out_s, O_MBUSY);
    end
    clear_inputs();
    resetN = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || stallCycles !== 16'd0 || out_s !== O_DEF) begin
      n_fail++; $display("FAIL mid_busy_reset got=%b/%0d exp=%b/0", out_s, stallCycles, O_DEF);
    end
    resetN = 1'b1;
    tick();
    n_checks++;
    if (out_s !== O_DEF || stallCycles !== 16'd0) begin
      n_fail++; $display("FAIL mid_busy_release got=%b/%0d exp=%b/0", out_s, stallCycles, O_DEF);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    idExMemRead = 1'b1; idExRt = 5'd12; ifIdRt = 5'd12; ifIdRs = 5'd1; ifIdValid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_checks++;
      if (s_stallCycles !== 3'((i > 7) ? 7 : i) || sat_out_s !== O_LU) begin
        n_fail++; $display("FAIL sat_step%0d got=%0d/%b exp=%0d/%b", i, s_stallCycles, sat_out_s,
                           (i > 7) ? 7 : i, O_LU);
      end
    end
    n_checks++;
    if (stallCycles !== 16'd10) begin
      n_fail++; $display("FAIL sat_wide_counter got=%0d exp=10", stallCycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_multi();
    test_reset_mid_busy();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
